// File: rtl/cpu_register_file_write_arbiter_if.sv
// Register file write-port bus: requester handshake, scrub control, write port.
// master = requester/controller side, slave = arbiter side.
interface cpu_register_file_write_arbiter_if #(
  parameter int NUMBER_OF_REGISTERS  = 256,
  parameter int NUMBER_OF_REQUESTERS = 4,
  parameter int DATA_WIDTH           = 4
);
  localparam int AW = $clog2(NUMBER_OF_REGISTERS);

  logic [NUMBER_OF_REQUESTERS-1:0]            request_valid_in;
  logic [NUMBER_OF_REQUESTERS*AW-1:0]         request_address_in;
  logic [NUMBER_OF_REQUESTERS*DATA_WIDTH-1:0] request_data_in;
  logic [NUMBER_OF_REQUESTERS-1:0]            request_ready_out;
  logic                                       scrub_start_in;
  logic                                       register_write_enable_out;
  logic [AW-1:0]                              register_write_address_out;
  logic [DATA_WIDTH-1:0]                      register_write_data_out;
  logic                                       busy_out;
  logic                                       scrub_done_out;

  modport master (
    output request_valid_in,
    output request_address_in,
    output request_data_in,
    output scrub_start_in,
    input  request_ready_out,
    input  register_write_enable_out,
    input  register_write_address_out,
    input  register_write_data_out,
    input  busy_out,
    input  scrub_done_out
  );

  modport slave (
    input  request_valid_in,
    input  request_address_in,
    input  request_data_in,
    input  scrub_start_in,
    output request_ready_out,
    output register_write_enable_out,
    output register_write_address_out,
    output register_write_data_out,
    output busy_out,
    output scrub_done_out
  );
endinterface

// File: rtl/cpu_register_file_write_arbiter.sv
// Round-robin arbiter for the register file write port, with a zeroing scrub.
// Ports: clock_in, reset_in (async active-low), bus (slave modport).
module cpu_register_file_write_arbiter #(
  parameter int NUMBER_OF_REGISTERS  = 256,
  parameter int NUMBER_OF_REQUESTERS = 4,
  parameter int DATA_WIDTH           = 4
) (
  input  logic clock_in,
  input  logic reset_in,
  cpu_register_file_write_arbiter_if.slave bus
);
  localparam int AW = $clog2(NUMBER_OF_REGISTERS);
  localparam int GW = $clog2(NUMBER_OF_REQUESTERS);
  localparam int NR = NUMBER_OF_REQUESTERS;
  localparam int DW = DATA_WIDTH;

  typedef enum logic [1:0] {
    ARBITRATE,
    SCRUB,
    DONE
  } state_t;

  state_t           state;
  logic [GW-1:0]    last_grant;
  logic [AW:0]      counter;
  logic             write_enable;
  logic [AW-1:0]    write_address;
  logic [DW-1:0]    write_data;

  logic [NR-1:0]    grant;
  logic [GW-1:0]    winner;
  logic [GW-1:0]    idx;
  logic             found;
  logic             open;
  logic [AW-1:0]    win_address;
  logic [DW-1:0]    win_data;

  // Scrub start wins over any pending request in the same cycle.
  assign open = (state == ARBITRATE) && !bus.scrub_start_in;

  always_comb begin
    grant  = '0;
    winner = '0;
    idx    = '0;
    found  = 1'b0;
    for (int i = 1; i <= NR; i++) begin
      idx = GW'((int'(last_grant) + i) % NR);
      if (!found && bus.request_valid_in[idx]) begin
        found       = 1'b1;
        winner      = idx;
        grant[idx]  = 1'b1;
      end
    end
    win_address = bus.request_address_in[winner*AW +: AW];
    win_data    = bus.request_data_in[winner*DW +: DW];
  end

  assign bus.request_ready_out =
    (open && reset_in) ? grant : '0;

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state         <= ARBITRATE;
      last_grant    <= GW'(NR - 1);
      counter       <= '0;
      write_enable  <= 1'b0;
      write_address <= '0;
      write_data    <= '0;
    end else begin
      unique case (state)
        ARBITRATE: begin
          if (bus.scrub_start_in) begin
            state        <= SCRUB;
            counter      <= (AW+1)'(1);
            write_enable <= 1'b0;
          end else if (found) begin
            last_grant    <= winner;
            // Register 0 is hard-wired: accept, but never write it.
            write_enable  <= (win_address != '0);
            write_address <= win_address;
            write_data    <= win_data;
          end else begin
            write_enable <= 1'b0;
          end
        end
        SCRUB: begin
          write_enable  <= 1'b1;
          write_address <= counter[AW-1:0];
          write_data    <= '0;
          counter       <= counter + (AW+1)'(1);
          if (counter == (AW+1)'(NUMBER_OF_REGISTERS - 1))
            state <= DONE;
        end
        DONE: begin
          write_enable <= 1'b0;
          counter      <= '0;
          state        <= ARBITRATE;
        end
        default: begin
          write_enable <= 1'b0;
          state        <= ARBITRATE;
        end
      endcase
    end
  end

  assign bus.register_write_enable_out  = write_enable;
  assign bus.register_write_address_out = write_address;
  assign bus.register_write_data_out    = write_data;
  assign bus.busy_out                   = (state == SCRUB);
  assign bus.scrub_done_out             = (state == DONE);
endmodule

// File: tb/tb_cpu_register_file_write_arbiter.sv
// Bench for cpu_register_file_write_arbiter: directed plan plus random traffic.
// Checks every cycle against a behavioural model of the write port.
module tb_cpu_register_file_write_arbiter;
  localparam int NREG = 256;
  localparam int NREQ = 4;
  localparam int DW   = 4;
  localparam int AW   = 8;

  logic clock_in = 1'b0;
  logic reset_in = 1'b0;
  always #5 clock_in = ~clock_in;

  cpu_register_file_write_arbiter_if #(
    .NUMBER_OF_REGISTERS (NREG),
    .NUMBER_OF_REQUESTERS(NREQ),
    .DATA_WIDTH          (DW)
  ) bus ();

  cpu_register_file_write_arbiter #(
    .NUMBER_OF_REGISTERS (NREG),
    .NUMBER_OF_REQUESTERS(NREQ),
    .DATA_WIDTH          (DW)
  ) u_dut (
    .clock_in(clock_in),
    .reset_in(reset_in),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  // pending requests (held until granted)
  bit            pv[NREQ];
  logic [AW-1:0] pa[NREQ];
  logic [DW-1:0] pd[NREQ];

  // model: phase 0 serving, 1 scrubbing, 2 done cycle
  int            phase;
  int            nxt;
  int            mlast;
  logic          men;
  logic [AW-1:0] maddr;
  logic [DW-1:0] mdata;
  int            done_seen;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic apply(bit scrub);
    for (int k = 0; k < NREQ; k++) begin
      bus.request_valid_in[k]             = pv[k];
      bus.request_address_in[k*AW +: AW]  = pa[k];
      bus.request_data_in[k*DW +: DW]     = pd[k];
    end
    bus.scrub_start_in = scrub;
  endtask

  task automatic model_reset();
    phase = 0;
    nxt   = 0;
    mlast = NREQ - 1;
    men   = 1'b0;
    maddr = '0;
    mdata = '0;
  endtask

  task automatic step(bit scrub);
    int g;
    logic [NREQ-1:0] er;
    @(negedge clock_in);
    apply(scrub);
    #1;
    g  = -1;
    er = '0;
    if (phase == 0 && !scrub)
      for (int i = 1; i <= NREQ; i++) begin
        int k;
        k = (mlast + i) % NREQ;
        if (g < 0 && pv[k]) g = k;
      end
    if (g >= 0) er[g] = 1'b1;
    check("ready", bus.request_ready_out, er);
    check("we", bus.register_write_enable_out, men);
    check("waddr", bus.register_write_address_out, maddr);
    check("wdata", bus.register_write_data_out, mdata);
    check("busy", bus.busy_out, phase == 1);
    check("done", bus.scrub_done_out, phase == 2);
    if (bus.scrub_done_out) done_seen++;
    case (phase)
      0: begin
        if (scrub) begin
          phase = 1;
          nxt   = 1;
          men   = 1'b0;
        end else if (g >= 0) begin
          mlast = g;
          men   = (pa[g] != 0);
          maddr = pa[g];
          mdata = pd[g];
          pv[g] = 1'b0;
        end else begin
          men = 1'b0;
        end
      end
      1: begin
        men   = 1'b1;
        maddr = AW'(nxt);
        mdata = '0;
        if (nxt == NREG - 1) phase = 2;
        nxt++;
      end
      default: begin
        men   = 1'b0;
        phase = 0;
      end
    endcase
  endtask

  task automatic do_reset();
    @(negedge clock_in);
    for (int k = 0; k < NREQ; k++) pv[k] = 1'b1;
    apply(1'b0);
    reset_in = 1'b0;
    #1;
    check("rst_ready", bus.request_ready_out, 0);
    check("rst_we", bus.register_write_enable_out, 0);
    check("rst_waddr", bus.register_write_address_out, 0);
    check("rst_wdata", bus.register_write_data_out, 0);
    check("rst_busy", bus.busy_out, 0);
    check("rst_done", bus.scrub_done_out, 0);
    @(negedge clock_in);
    for (int k = 0; k < NREQ; k++) pv[k] = 1'b0;
    apply(1'b0);
    #1;
    reset_in = 1'b1;
    model_reset();
  endtask

  task automatic req(int k, logic [AW-1:0] a, logic [DW-1:0] d);
    pv[k] = 1'b1;
    pa[k] = a;
    pd[k] = d;
  endtask

  initial begin
    for (int k = 0; k < NREQ; k++) begin
      pv[k] = 1'b0;
      pa[k] = '0;
      pd[k] = '0;
    end
    apply(1'b0);
    model_reset();
    done_seen = 0;
    do_reset();

    // lone requester 2
    req(2, 8'h05, 4'b1101);
    step(1'b0);
    step(1'b0);
    step(1'b0);

    // all four held valid: 0,1,2,3,0,1,2,3
    do_reset();
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < NREQ; k++)
        if (!pv[k]) req(k, AW'(8'h10 + c*4 + k), DW'(c + k));
      step(1'b0);
    end
    for (int k = 0; k < NREQ; k++) pv[k] = 1'b0;
    step(1'b0);

    // address 0 handshake, no write
    req(1, 8'h00, 4'b0111);
    step(1'b0);
    step(1'b0);

    // scrub with a second ignored pulse at 0x40
    do_reset();
    done_seen = 0;
    req(0, 8'h21, 4'h3);
    req(3, 8'h22, 4'h9);
    step(1'b1);
    for (int c = 0; c < 300 && phase != 0; c++)
      step(phase == 1 && maddr == 8'h40);
    check("scrub_end", phase, 0);
    step(1'b0);
    check("done_count", done_seen, 1);
    step(1'b0);
    step(1'b0);

    // async reset mid-scrub at 0x80
    done_seen = 0;
    req(0, 8'h31, 4'h5);
    req(3, 8'h32, 4'hA);
    step(1'b1);
    for (int c = 0; c < 300 && !(phase == 1 && maddr == 8'h80); c++)
      step(1'b0);
    check("reach_80", maddr, 8'h80);
    @(negedge clock_in);
    #3;
    reset_in = 1'b0;
    #1;
    check("arst_ready", bus.request_ready_out, 0);
    check("arst_we", bus.register_write_enable_out, 0);
    check("arst_waddr", bus.register_write_address_out, 0);
    check("arst_wdata", bus.register_write_data_out, 0);
    check("arst_busy", bus.busy_out, 0);
    check("arst_done", bus.scrub_done_out, 0);
    model_reset();
    for (int k = 0; k < NREQ; k++) pv[k] = 1'b0;
    apply(1'b0);
    @(negedge clock_in);
    #1;
    reset_in = 1'b1;
    for (int k = 0; k < NREQ; k++) req(k, AW'(8'h40 + k), DW'(k + 8));
    for (int c = 0; c < 300; c++) step(1'b0);
    check("no_done_after_rst", done_seen, 0);

    // random traffic
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < NREQ; k++)
        if (!pv[k] && $urandom_range(1, 0) == 1) begin
          pv[k] = 1'b1;
          pa[k] = ($urandom_range(7, 0) == 0) ? '0 : AW'($urandom);
          pd[k] = DW'($urandom);
        end
      step($urandom_range(199, 0) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
